// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default width for pipeline stage registers
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY = 2'b00, PS_ONE = 2'b10, PS_FULL = 2'b11} pipe_state_t;
    localparam int PIPE_DEFAULT_W = 32;
endpackage

// File: rtl/pipe_data_slot.sv
// pipe_data_slot: payload register with load enable and sync reset to RESET_VAL
module pipe_data_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DEFAULT_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= RESET_VAL;
        else if (load) q <= d;
endmodule

// File: rtl/pipe_skid_register.sv
// pipe_skid_register: valid/ready pipeline stage with 2-entry skid buffer and registered in_ready
// Optional stall counter port stall_cycles when PIPE_SKID_STATS_EN is defined.
module pipe_skid_register
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DEFAULT_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);
    pipe_state_t       state_q, state_d;
    logic              in_fire, out_fire, load_main, load_skid, sel_skid;
    logic [DATA_W-1:0] skid_data;
    assign out_valid = state_q[1];
    assign in_ready  = !state_q[0];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    always_ff @(posedge clk)
        if (rst) state_q <= PS_EMPTY;
        else state_q <= state_d;
    always_comb begin
        state_d   = PS_EMPTY;
        load_main = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        case (state_q)
            PS_EMPTY: begin
                state_d   = in_fire ? PS_ONE : PS_EMPTY;
                load_main = in_fire;
            end
            PS_ONE: begin
                state_d   = (in_fire && !out_fire) ? PS_FULL : (!in_fire && out_fire) ? PS_EMPTY : PS_ONE;
                load_main = in_fire && out_fire;
                load_skid = in_fire && !out_fire;
            end
            PS_FULL: begin
                state_d   = out_fire ? PS_ONE : PS_FULL;
                load_main = out_fire;
                sel_skid  = 1'b1;
            end
            default: state_d = PS_EMPTY;
        endcase
        // flush empties the stage but leaves slot contents untouched
        if (flush) begin
            state_d   = PS_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end
    pipe_data_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .rst(rst), .load(load_main), .d(sel_skid ? skid_data : in_data), .q(out_data)
    );
    pipe_data_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
        .clk(clk), .rst(rst), .load(load_skid), .d(in_data), .q(skid_data)
    );
`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge clk)
        if (rst) stall_cycles <= '0;
        else if (out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
`endif
endmodule

// File: tb/tb_pipe_skid_register.sv
// tb_pipe_skid_register: directed vector table, scoreboarded random stream, stall counter checks
module tb_pipe_skid_register;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
`ifdef PIPE_SKID_STATS_EN
    logic [3:0] stall_cycles;
`endif
    pipe_skid_register #(.DATA_W(32), .RESET_VAL(32'h0), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );
    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] d;
        logic        ordy, e_ov, e_ir;
        logic [31:0] e_od;
        logic        chk_od;
    } vec_t;
    vec_t        vec[22];
    logic [31:0] q[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic o);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        //          rst flush iv  data    ordy ov ir  out_data chk_od
        vec[0]  = '{1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 1};
        vec[1]  = '{1, 0, 0, 32'h0, 0, 0, 1, 32'h0, 1};
        vec[2]  = '{0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 1};
        vec[3]  = '{0, 0, 1, 32'h1, 1, 1, 1, 32'h1, 1};
        vec[4]  = '{0, 0, 1, 32'h2, 1, 1, 1, 32'h2, 1};
        vec[5]  = '{0, 0, 1, 32'h3, 1, 1, 1, 32'h3, 1};
        vec[6]  = '{0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
        vec[7]  = '{0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 1};
        vec[8]  = '{0, 0, 1, 32'hB, 0, 1, 0, 32'hA, 1};
        vec[9]  = '{0, 0, 1, 32'hC, 0, 1, 0, 32'hA, 1};
        vec[10] = '{0, 0, 0, 32'h0, 1, 1, 1, 32'hB, 1};
        vec[11] = '{0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
        vec[12] = '{0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 1};
        vec[13] = '{0, 0, 1, 32'hB, 0, 1, 0, 32'hA, 1};
        vec[14] = '{0, 1, 0, 32'h0, 0, 0, 1, 32'h0, 0};
        vec[15] = '{0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
        vec[16] = '{0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
        vec[17] = '{1, 0, 1, 32'h5, 0, 0, 1, 32'h0, 1};
        vec[18] = '{0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 1};
        vec[19] = '{0, 0, 1, 32'h7, 0, 1, 1, 32'h7, 1};
        vec[20] = '{0, 1, 1, 32'h8, 0, 0, 1, 32'h0, 0};
        vec[21] = '{0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 0};
        drive(1, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(vec[i].rst, vec[i].flush, vec[i].iv, vec[i].d, vec[i].ordy);
            cyc();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_ir));
            if (vec[i].chk_od) chk($sformatf("vec%0d_out_data", i), out_data, vec[i].e_od);
        end
        // random stream against a queue model of the stage
        drive(1, 0, 0, 0, 0);
        cyc();
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic        iv, o, f, ifire, ofire;
            logic [31:0] d, shown, popped;
            iv = 1'($urandom_range(0, 1));
            o  = $urandom_range(0, 3) != 0;
            f  = $urandom_range(0, 40) == 0;
            d  = $urandom;
            shown = out_data;
            drive(0, f, iv, d, o);
            ifire = iv && q.size() < 2;
            ofire = q.size() > 0 && o;
            @(posedge clk);
            if (f) q.delete();
            else begin
                if (ofire) begin
                    popped = q.pop_front();
                    chk("sb_pop_data", shown, popped);
                end
                if (ifire) q.push_back(d);
            end
            #1;
            chk("sb_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("sb_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) chk("sb_out_data", out_data, q[0]);
        end
`ifdef PIPE_SKID_STATS_EN
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("stall_reset", 32'(stall_cycles), 32'd0);
        drive(0, 0, 1, 32'h9, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("stall_count3", 32'(stall_cycles), 32'd3);
        repeat (17) cyc();
        chk("stall_saturate", 32'(stall_cycles), 32'd15);
        drive(0, 1, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        cyc();
        chk("stall_after_flush", 32'(stall_cycles), 32'd15);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("stall_after_rst", 32'(stall_cycles), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
